hazard_sequencer: RTL and testbench

HAZARD_SEQUENCER -- requirements
Module: hazard_sequencer

---
 rtl/hazard_sequencer_if.sv | 50 +++++
 rtl/hazard_sequencer.sv | 154 +++++++++++++++
 tb/tb_hazard_sequencer.sv | 199 +++++++++++++++++++
 3 files changed

// File: rtl/hazard_sequencer_if.sv
// Pipeline-control bus between the ID/EX stages and the hazard sequencer.
// Optional feature macro: HAZARD_STALL_STATS_EN adds the stall_cnt statistic.
interface hazard_sequencer_if;
  localparam int unsigned OP_W   = 4;
  localparam int unsigned REG_W  = 4;
  localparam int unsigned STAT_W = 16;

  // ID-stage instruction fields
  logic [OP_W-1:0]  id_opcode;
  logic [OP_W-1:0]  id_func;
  logic [REG_W-1:0] id_rs;
  logic [REG_W-1:0] id_rt;

  // EX-stage load information and branch resolution
  logic             ex_mread;
  logic [REG_W-1:0] ex_rd;
  logic             jorb;

  // Pipeline control outputs
  logic             pc_write;
  logic             ifid_write;
  logic             ifid_flush;
  logic             idex_bubble;
  logic             md_busy;
  logic             halted;

`ifdef HAZARD_STALL_STATS_EN
  logic [STAT_W-1:0] stall_cnt;

  modport master (
    output id_opcode, id_func, id_rs, id_rt, ex_mread, ex_rd, jorb,
    input  pc_write, ifid_write, ifid_flush, idex_bubble, md_busy, halted, stall_cnt
  );

  modport slave (
    input  id_opcode, id_func, id_rs, id_rt, ex_mread, ex_rd, jorb,
    output pc_write, ifid_write, ifid_flush, idex_bubble, md_busy, halted, stall_cnt
  );
`else
  modport master (
    output id_opcode, id_func, id_rs, id_rt, ex_mread, ex_rd, jorb,
    input  pc_write, ifid_write, ifid_flush, idex_bubble, md_busy, halted
  );

  modport slave (
    input  id_opcode, id_func, id_rs, id_rt, ex_mread, ex_rd, jorb,
    output pc_write, ifid_write, ifid_flush, idex_bubble, md_busy, halted
  );
`endif
endinterface

// File: rtl/hazard_sequencer.sv
// Hazard sequencer: load-use stalls, branch flushes, multi-cycle mul/div
// occupancy of EX and halt handling for the 5-stage pipeline.
// Control outputs are combinational so stalls and flushes act in the same cycle.
// Optional feature macro: HAZARD_STALL_STATS_EN adds a saturating stall counter.
module hazard_sequencer #(
  parameter int unsigned MD_CYCLES = 4
) (
  input  logic               clk,
  input  logic               reset,
  hazard_sequencer_if.slave  bus
);

  localparam int unsigned CNT_W  = 4;
  localparam int unsigned STAT_W = 16;

  localparam logic [3:0] OP_ATYPE = 4'b0000;
  localparam logic [3:0] OP_HALT  = 4'b1111;
  localparam logic [3:0] FN_MUL   = 4'b0100;
  localparam logic [3:0] FN_DIV   = 4'b1000;

  // Counter preload: the issue cycle itself accounts for one EX cycle
  localparam logic [CNT_W-1:0] MD_LOAD = CNT_W'(MD_CYCLES - 1);

  typedef enum logic [1:0] {
    ST_RUN     = 2'd0,
    ST_MD_WAIT = 2'd1,
    ST_HALT    = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] md_cnt_q, md_cnt_d;

  logic load_use;
  logic md_op;
  logic halt_op;

  logic pc_write;
  logic ifid_write;
  logic ifid_flush;
  logic idex_bubble;
  logic md_busy;
  logic halted;

  // Instruction in ID needs the value a load in EX has not yet produced
  assign load_use = !bus.ex_mread &&
                    ((bus.ex_rd == bus.id_rs) || (bus.ex_rd == bus.id_rt));

  // ID decode of the two instruction classes that change sequencing
  assign md_op   = (bus.id_opcode == OP_ATYPE) &&
                   ((bus.id_func == FN_MUL) || (bus.id_func == FN_DIV));
  assign halt_op = (bus.id_opcode == OP_HALT);

  // State and occupancy counter registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= ST_RUN;
      md_cnt_q <= '0;
    end else begin
      state_q  <= state_d;
      md_cnt_q <= md_cnt_d;
    end
  end

  // Next-state and pipeline control decode
  always_comb begin
    state_d     = state_q;
    md_cnt_d    = md_cnt_q;
    pc_write    = 1'b1;
    ifid_write  = 1'b1;
    ifid_flush  = 1'b0;
    idex_bubble = 1'b0;
    md_busy     = 1'b0;
    halted      = 1'b0;

    unique case (state_q)
      ST_RUN: begin
        if (load_use) begin
          // Stall has priority; a concurrent branch is seen again next cycle
          pc_write    = 1'b0;
          ifid_write  = 1'b0;
          idex_bubble = 1'b1;
        end else begin
          if (bus.jorb) begin
            ifid_flush = 1'b1;
          end
          if (halt_op) begin
            ifid_flush = 1'b1;
            state_d    = ST_HALT;
          end else if (md_op) begin
            state_d  = ST_MD_WAIT;
            md_cnt_d = MD_LOAD;
          end
        end
      end

      ST_MD_WAIT: begin
        // EX is occupied: freeze the front end and ignore branch resolution
        pc_write    = 1'b0;
        ifid_write  = 1'b0;
        idex_bubble = 1'b1;
        md_busy     = 1'b1;
        md_cnt_d    = md_cnt_q - CNT_W'(1);
        if (md_cnt_q <= CNT_W'(1)) begin
          state_d = ST_RUN;
        end
      end

      ST_HALT: begin
        pc_write    = 1'b0;
        ifid_write  = 1'b0;
        idex_bubble = 1'b1;
        halted      = 1'b1;
      end

      default: begin
        state_d  = ST_RUN;
        md_cnt_d = '0;
      end
    endcase
  end

  assign bus.pc_write    = pc_write;
  assign bus.ifid_write  = ifid_write;
  assign bus.ifid_flush  = ifid_flush;
  assign bus.idex_bubble = idex_bubble;
  assign bus.md_busy     = md_busy;
  assign bus.halted      = halted;

`ifdef HAZARD_STALL_STATS_EN
  logic [STAT_W-1:0] stall_cnt_q, stall_cnt_d;

  // Count frozen-PC cycles while running, saturating at all-ones
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (!pc_write && !halted && (stall_cnt_q != {STAT_W{1'b1}})) begin
      stall_cnt_d = stall_cnt_q + STAT_W'(1);
    end
  end

  // Stall statistic register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stall_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign bus.stall_cnt = stall_cnt_q;
`else
  // No stall statistics in this build
`endif

endmodule

// File: tb/tb_hazard_sequencer.sv
// Self-checking bench for hazard_sequencer: directed scenarios followed by
// randomized traffic, all checked against a cycle-level behavioural model.
// Build with HAZARD_STALL_STATS_EN defined to also exercise stall_cnt.
module tb_hazard_sequencer;

  localparam int unsigned MD_CYCLES = 4;

  logic clk;
  logic reset;

  hazard_sequencer_if bus();

  hazard_sequencer #(.MD_CYCLES(MD_CYCLES)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // Behavioural model state: busy cycles still owed to EX, halt flag, stall tally
  int md_left = 0;
  bit hlt     = 1'b0;
  int stall_model = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: observed %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // One clock of stimulus: drive after the falling edge, check, then advance the model
  task automatic step(input bit rst_n, input logic [3:0] opc, input logic [3:0] func,
                      input logic [3:0] rs, input logic [3:0] rt, input bit mread,
                      input logic [3:0] rd, input bit jb);
    bit lu;
    bit e_pc, e_ifw, e_fl, e_bub, e_busy, e_h;
    @(negedge clk);
    reset         = rst_n;
    bus.id_opcode = opc;
    bus.id_func   = func;
    bus.id_rs     = rs;
    bus.id_rt     = rt;
    bus.ex_mread  = mread;
    bus.ex_rd     = rd;
    bus.jorb      = jb;
    if (!rst_n) begin
      md_left     = 0;
      hlt         = 1'b0;
      stall_model = 0;
    end
    lu = !mread && ((rd == rs) || (rd == rt));
    if (hlt) begin
      {e_pc, e_ifw, e_fl, e_bub, e_busy, e_h} = 6'b000101;
    end else if (md_left > 0) begin
      {e_pc, e_ifw, e_fl, e_bub, e_busy, e_h} = 6'b000110;
    end else if (lu) begin
      {e_pc, e_ifw, e_fl, e_bub, e_busy, e_h} = 6'b000100;
    end else begin
      e_pc = 1'b1; e_ifw = 1'b1; e_bub = 1'b0; e_busy = 1'b0; e_h = 1'b0;
      e_fl = jb || (opc == 4'hF);
    end
    #1;
    check_eq("pc_write",    32'(bus.pc_write),    32'(e_pc));
    check_eq("ifid_write",  32'(bus.ifid_write),  32'(e_ifw));
    check_eq("ifid_flush",  32'(bus.ifid_flush),  32'(e_fl));
    check_eq("idex_bubble", 32'(bus.idex_bubble), 32'(e_bub));
    check_eq("md_busy",     32'(bus.md_busy),     32'(e_busy));
    check_eq("halted",      32'(bus.halted),      32'(e_h));
`ifdef HAZARD_STALL_STATS_EN
    check_eq("stall_cnt",   32'(bus.stall_cnt),   32'(stall_model));
`endif
    if (rst_n) begin
      if (!e_pc && !e_h && stall_model < 65535) stall_model++;
      if (hlt) begin
        hlt = 1'b1;
      end else if (md_left > 0) begin
        md_left--;
      end else if (!lu) begin
        if (opc == 4'hF) hlt = 1'b1;
        else if (opc == 4'h0 && (func == 4'h4 || func == 4'h8)) md_left = int'(MD_CYCLES) - 1;
      end
    end
  endtask

  // Plain ALU instruction, no load in EX, no branch
  task automatic idle(input bit rst_n);
    step(rst_n, 4'h2, 4'h0, 4'h1, 4'h2, 1'b1, 4'h0, 1'b0);
  endtask

  initial begin
    int busy_cycles;
    reset         = 1'b0;
    bus.id_opcode = 4'h2;
    bus.id_func   = 4'h0;
    bus.id_rs     = 4'h1;
    bus.id_rt     = 4'h2;
    bus.ex_mread  = 1'b1;
    bus.ex_rd     = 4'h0;
    bus.jorb      = 1'b0;

    // Reset state, then release
    idle(1'b0);
    idle(1'b0);
    check_eq("rst_pc_write", 32'(bus.pc_write), 32'd1);
    idle(1'b1);

    // Single load-use stall on rs, one cycle only
    step(1'b1, 4'h2, 4'h0, 4'h3, 4'h7, 1'b0, 4'h3, 1'b0);
    check_eq("lu_bubble", 32'(bus.idex_bubble), 32'd1);
    idle(1'b1);
    check_eq("lu_release", 32'(bus.pc_write), 32'd1);

    // Stall beats branch, branch taken the following cycle
    step(1'b1, 4'h2, 4'h0, 4'h1, 4'h5, 1'b0, 4'h5, 1'b1);
    check_eq("lu_jorb_flush", 32'(bus.ifid_flush), 32'd0);
    step(1'b1, 4'h2, 4'h0, 4'h1, 4'h5, 1'b1, 4'h5, 1'b1);
    check_eq("jorb_flush", 32'(bus.ifid_flush), 32'd1);

    // Multiply occupancy with branches arriving while EX is busy
    step(1'b1, 4'h0, 4'h4, 4'h1, 4'h2, 1'b1, 4'h0, 1'b0);
    busy_cycles = 0;
    for (int i = 0; i < MD_CYCLES + 1; i++) begin
      step(1'b1, 4'h2, 4'h0, 4'h1, 4'h2, 1'b1, 4'h0, 1'b1);
      busy_cycles += int'(bus.md_busy);
    end
    check_eq("md_busy_len", 32'(busy_cycles), 32'(MD_CYCLES - 1));

    // A-type with another func passes straight through
    step(1'b1, 4'h0, 4'h5, 4'h1, 4'h2, 1'b1, 4'h0, 1'b0);
    idle(1'b1);
    check_eq("atype_other", 32'(bus.md_busy), 32'd0);

    // Halt holds for many cycles and only reset leaves it
    step(1'b1, 4'hF, 4'h0, 4'h1, 4'h2, 1'b1, 4'h0, 1'b0);
    for (int i = 0; i < 22; i++) begin
      step(1'b1, 4'(i), 4'h4, 4'h1, 4'h2, 1'b1, 4'h0, 1'(i % 2));
    end
    check_eq("halt_hold", 32'(bus.halted), 32'd1);
    idle(1'b0);
    idle(1'b1);
    check_eq("halt_exit_pc", 32'(bus.pc_write), 32'd1);

    // Reset in the second divide wait cycle aborts the wait
    step(1'b1, 4'h0, 4'h8, 4'h1, 4'h2, 1'b1, 4'h0, 1'b0);
    idle(1'b1);
    idle(1'b0);
    check_eq("abort_md_busy", 32'(bus.md_busy), 32'd0);
    idle(1'b1);
    check_eq("abort_pc_write", 32'(bus.pc_write), 32'd1);
    idle(1'b1);

    // Randomized traffic
    for (int i = 0; i < 4000; i++) begin
      bit          rst_n;
      logic [3:0]  opc, func;
      int          sel;
      rst_n = ($urandom_range(0, hlt ? 15 : 199) != 0);
      sel   = int'($urandom_range(0, 59));
      func  = 4'($urandom_range(0, 15));
      if (sel < 12)       begin opc = 4'h0; func = ($urandom_range(0, 1) != 0) ? 4'h4 : 4'h8; end
      else if (sel < 18)  opc = 4'h0;
      else if (sel == 59) opc = 4'hF;
      else                opc = 4'($urandom_range(1, 14));
      if (!rst_n && opc == 4'hF) opc = 4'h1;
      step(rst_n, opc, func, 4'($urandom_range(0, 3)), 4'($urandom_range(0, 3)),
           1'($urandom_range(0, 1)), 4'($urandom_range(0, 3)),
           rst_n && ($urandom_range(0, 3) == 0));
    end

`ifdef HAZARD_STALL_STATS_EN
    // Divide plus one load-use stall gives four stall cycles
    idle(1'b0);
    idle(1'b1);
    step(1'b1, 4'h0, 4'h8, 4'h1, 4'h2, 1'b1, 4'h0, 1'b0);
    for (int i = 0; i < MD_CYCLES - 1; i++) idle(1'b1);
    step(1'b1, 4'h2, 4'h0, 4'h6, 4'h2, 1'b0, 4'h6, 1'b0);
    idle(1'b1);
    check_eq("stall_cnt_4", 32'(bus.stall_cnt), 32'd4);

    // Long load-use stall saturates the counter
    for (int i = 0; i < 70000; i++) begin
      step(1'b1, 4'h2, 4'h0, 4'h6, 4'h2, 1'b0, 4'h6, 1'b0);
    end
    idle(1'b1);
    check_eq("stall_cnt_sat", 32'(bus.stall_cnt), 32'h0000FFFF);
`endif

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
